// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selection, transmitter state encoding and
// the bit-period helper reused by the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_ODD,
    PARITY_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_tx_state_t;

  // Clock cycles per serial bit; truncating division.
  function automatic int bit_period(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..BIT_PERIOD-1 while enabled and pulses bit_done
// on the last cycle of each bit. clear restarts the count from zero.
module uart_baud_tick #(
  parameter int BIT_PERIOD = 10,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             bit_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    bit_done = enable && (cnt_q == LAST);
    cnt_d    = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/uart_tx.sv
// AXI4-Stream to UART serializer: start bit, data LSB first, optional parity,
// 1 or 2 stop bits. tx_wire and s_axis_tready are both flop outputs.
module uart_tx
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ   = 50_000_000,
  parameter int      BAUD_RATE  = 9600,
  parameter int      DATA_WIDTH = 8,
  parameter parity_t PARITY     = PARITY_NONE,
  parameter int      STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  tx_wire,
  output logic                  tx_busy
);

  localparam int BIT_PERIOD = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W      = ($clog2(BIT_PERIOD) > 0) ? $clog2(BIT_PERIOD) : 1;
  localparam int BIT_W      = $clog2(DATA_WIDTH) + 1;

  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(BIT_PERIOD - 2);

  if (BIT_PERIOD < 2) begin : g_bad_bit_period
    $error("uart_tx: BIT_PERIOD = CLK_FREQ / BAUD_RATE must be at least 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
    $error("uart_tx: DATA_WIDTH must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_tx_state_t        state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  tready_q, tready_d;

  logic                  handshake;
  logic                  baud_clear;
  logic                  baud_enable;
  logic [CNT_W-1:0]      baud_cnt;
  logic                  bit_done;

  // Valid/ready: a word transfers on a rising edge where s_axis_tvalid and the
  // registered s_axis_tready are both high; tready never depends on tvalid.
  assign handshake   = s_axis_tvalid && tready_q;
  assign baud_clear  = (state_d != state_q);
  assign baud_enable = (state_q != IDLE);

  uart_baud_tick #(
    .BIT_PERIOD (BIT_PERIOD),
    .CNT_W      (CNT_W)
  ) u_baud_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (baud_clear),
    .enable   (baud_enable),
    .cnt      (baud_cnt),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d   = START;
          shift_d   = s_axis_tdata;
          parity_d  = (PARITY == PARITY_ODD);
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        // Parity accumulates from the latched word as its bits leave the shifter.
        if (bit_done) begin
          shift_d  = shift_q >> 1;
          parity_d = parity_q ^ shift_q[0];
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PARITY_NONE) ? PAR : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      PAR: begin
        if (bit_done) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            if (handshake) begin
              state_d  = START;
              shift_d  = s_axis_tdata;
              parity_d = (PARITY == PARITY_ODD);
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase

    // The line follows the state one cycle later, so the start bit begins on
    // the edge after the handshake.
    unique case (state_q)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PAR:     tx_d = parity_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase

    // Ready is registered, so it is raised one cycle ahead of the final stop clock.
    tready_d = (state_d == IDLE) ||
               ((state_q == STOP) && !bit_done &&
                (bit_cnt_q == LAST_STOP) && (baud_cnt == PRE_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      tready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      tready_q  <= tready_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign tx_wire       = tx_q;
  assign tx_busy       = (state_q != IDLE);

endmodule
